// File: rtl/spi_bit_engine_if.sv
// Parallel-side bus of the SPI bit engine: shift controls, TX byte in,
// received byte and bit count out. "master" is the controlling logic,
// "slave" is the engine itself.
interface spi_bit_engine_if #(
  parameter int DATA_WIDTH = 8
);
  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic                  i_shift_en;
  logic                  i_shift_reg_direction;
  logic                  i_shift_reg_par_load;
  logic [DATA_WIDTH-1:0] i_tx_byte;
  logic                  i_count_clr;
  logic                  o_byte_is_ready;
  logic [DATA_WIDTH-1:0] o_recieved_byte;
  logic [CW-1:0]         o_bit_count;

  modport master (
    output i_shift_en, i_shift_reg_direction, i_shift_reg_par_load,
           i_tx_byte, i_count_clr,
    input  o_byte_is_ready, o_recieved_byte, o_bit_count
  );

  modport slave (
    input  i_shift_en, i_shift_reg_direction, i_shift_reg_par_load,
           i_tx_byte, i_count_clr,
    output o_byte_is_ready, o_recieved_byte, o_bit_count
  );
endinterface

// File: rtl/spi_bit_engine.sv
// SPI mode-0 slave bit engine. Pins are synchronized into i_clk, SCLK edges
// become one-cycle strobes, RX shifts on rise strobes, TX shifts on fall
// strobes. o_fsm_state exposes the IDLE/ACTIVE state for observation.
//
// Byte handshake: o_byte_is_ready is a one-cycle pulse with no back-pressure;
// o_recieved_byte is already valid in the pulse cycle and holds until the
// next complete byte, so a consumer may sample it on the pulse or any later
// cycle before the next pulse.
module spi_bit_engine #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_spi_sclk,
  input  logic             i_spi_mosi,
  input  logic             i_spi_cs,
  output logic             o_spi_miso,
  output logic             o_fsm_state,
  spi_bit_engine_if.slave  bus
);
  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_t;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic                   r_sclk_d;
  logic                   r_mosi_d;
  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   w_active;
  logic                   w_cs_abort;
  logic                   w_shift_ok;
  logic                   w_sclk;
  logic                   w_cs;
  logic                   w_sclk_rise;
  logic                   w_sclk_fall;
  logic [DATA_WIDTH-1:0]  r_rx;
  logic [DATA_WIDTH-1:0]  w_rx_next;
  logic [DATA_WIDTH-1:0]  r_rx_byte;
  logic [CW-1:0]          r_bit_cnt;
  logic                   r_byte_ready;
  logic [DATA_WIDTH-1:0]  r_tx;
  logic                   r_tx_fresh;

  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs        = r_cs_sync[SYNC_STAGES-1];
  // MOSI is delayed by the same extra register as SCLK so both stay aligned.
  assign w_sclk_rise = w_sclk & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk & r_sclk_d;
  assign w_shift_ok  = w_active & ~w_cs_abort & bus.i_shift_en;

  // Pin synchronizers plus the edge-detect / MOSI alignment register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_cs_sync   <= '1;
      r_sclk_d    <= 1'b0;
      r_mosi_d    <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_spi_sclk};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_spi_mosi};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_spi_cs};
      r_sclk_d    <= w_sclk;
      r_mosi_d    <= r_mosi_sync[SYNC_STAGES-1];
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next state; w_cs_abort flags CS rising while a transfer is active.
  always_comb begin
    w_state_nxt = r_state;
    w_active    = 1'b0;
    w_cs_abort  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_cs) w_state_nxt = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        w_active = 1'b1;
        if (w_cs) begin
          w_state_nxt = ST_IDLE;
          w_cs_abort  = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // RX shift value: new bit enters the LSB end (MSB first) or MSB end (LSB first).
  always_comb begin
    w_rx_next = r_rx;
    if (bus.i_shift_reg_direction) w_rx_next = {r_mosi_d, r_rx[DATA_WIDTH-1:1]};
    else                           w_rx_next = {r_rx[DATA_WIDTH-2:0], r_mosi_d};
  end

  // RX path: bit counter, partial byte, completed byte and ready pulse.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_rx         <= '0;
      r_bit_cnt    <= '0;
      r_rx_byte    <= '0;
      r_byte_ready <= 1'b0;
    end else begin
      r_byte_ready <= 1'b0;
      if (bus.i_count_clr || w_cs_abort) begin
        r_rx      <= '0;
        r_bit_cnt <= '0;
      end else if (w_shift_ok && w_sclk_rise) begin
        if (r_bit_cnt == CNT_LAST) begin
          r_bit_cnt    <= '0;
          r_rx         <= '0;
          r_rx_byte    <= w_rx_next;
          r_byte_ready <= 1'b1;
        end else begin
          r_bit_cnt <= r_bit_cnt + CW'(1);
          r_rx      <= w_rx_next;
        end
      end
    end
  end

  // TX path: a parallel load wins; the first fall after a load only clears
  // tx_fresh so the loaded first bit stays on MISO for the master's next rise.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_tx       <= '0;
      r_tx_fresh <= 1'b0;
    end else if (bus.i_shift_reg_par_load) begin
      r_tx       <= bus.i_tx_byte;
      r_tx_fresh <= 1'b1;
    end else if (w_cs_abort) begin
      r_tx_fresh <= 1'b0;
    end else if (w_shift_ok && w_sclk_fall) begin
      if (r_tx_fresh)                     r_tx_fresh <= 1'b0;
      else if (bus.i_shift_reg_direction) r_tx <= {1'b0, r_tx[DATA_WIDTH-1:1]};
      else                                r_tx <= {r_tx[DATA_WIDTH-2:0], 1'b0};
    end
  end

  assign o_spi_miso = (r_state == ST_ACTIVE) ?
                      (bus.i_shift_reg_direction ? r_tx[0] : r_tx[DATA_WIDTH-1]) : 1'b0;
  assign o_fsm_state         = r_state;
  assign bus.o_byte_is_ready = r_byte_ready;
  assign bus.o_recieved_byte = r_rx_byte;
  assign bus.o_bit_count     = r_bit_cnt;
endmodule

// File: tb/tb_spi_bit_engine.sv
// Bench for spi_bit_engine: a task-driven SPI master on the pins, a loader
// for TX bytes, and a monitor that pops expected received bytes on each
// o_byte_is_ready pulse.
module tb_spi_bit_engine;
  localparam int W    = 8;
  localparam int S    = 2;   // synchronizer depth used by the DUT
  localparam int HALF = 8;   // SCLK half period in i_clk cycles

  logic clk = 1'b0;
  logic rst_n;
  logic sclk, mosi, cs, miso, fsm_dbg;

  spi_bit_engine_if #(.DATA_WIDTH(W)) tif();

  spi_bit_engine #(.DATA_WIDTH(W), .SYNC_STAGES(S)) dut (
    .i_clk      (clk),
    .i_rst      (rst_n),
    .i_spi_sclk (sclk),
    .i_spi_mosi (mosi),
    .i_spi_cs   (cs),
    .o_spi_miso (miso),
    .o_fsm_state(fsm_dbg),
    .bus        (tif.slave)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];
  logic         load_arm = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] miso_cap = '0;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One mode-0 bit: MOSI set while SCLK low, master samples MISO at rise.
  task automatic spi_bit(input logic b);
    mosi = b;
    tick(HALF);
    sclk = 1'b1;
    miso_cap = {miso_cap[W-2:0], miso};
    tick(HALF);
    sclk = 1'b0;
  endtask

  task automatic send_byte(input logic [W-1:0] d, input logic dir);
    tif.i_shift_reg_direction = dir;
    exp_q.push_back(d);
    for (int i = 0; i < W; i++) spi_bit(dir ? d[i] : d[W-1-i]);
  endtask

  // Monitor: every ready pulse must match the oldest expected byte.
  initial begin
    forever begin
      @(negedge clk);
      if (tif.o_byte_is_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pulse: got byte 0x%0h, expected no pulse", tif.o_recieved_byte);
        end else begin
          check("rx_byte", 32'(tif.o_recieved_byte), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // Loader: when armed, load the TX byte on the next ready pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (load_arm && tif.o_byte_is_ready === 1'b1) begin
        tif.i_tx_byte            = load_val;
        tif.i_shift_reg_par_load = 1'b1;
        load_arm                 = 1'b0;
        @(negedge clk);
        tif.i_shift_reg_par_load = 1'b0;
      end
    end
  end

  // Main directed sequence.
  initial begin
    rst_n = 1'b0; sclk = 1'b0; mosi = 1'b0; cs = 1'b1;
    tif.i_shift_en = 1'b1; tif.i_shift_reg_direction = 1'b0;
    tif.i_shift_reg_par_load = 1'b0; tif.i_tx_byte = '0; tif.i_count_clr = 1'b0;
    tick(3);
    check("rst_ready", 32'(tif.o_byte_is_ready), 0);
    check("rst_rx_byte", 32'(tif.o_recieved_byte), 0);
    check("rst_bit_count", 32'(tif.o_bit_count), 0);
    check("rst_miso", 32'(miso), 0);
    check("rst_state", 32'(fsm_dbg), 0);
    rst_n = 1'b1;
    tick(5);

    // SCLK toggling with CS high is ignored.
    for (int i = 0; i < 4; i++) spi_bit(1'b1);
    tick(6);
    check("idle_bit_count", 32'(tif.o_bit_count), 0);
    check("idle_state", 32'(fsm_dbg), 0);

    // 0xA5 MSB first, then LSB first.
    cs = 1'b0;
    tick(6);
    check("active_state", 32'(fsm_dbg), 1);
    send_byte(8'hA5, 1'b0);
    tick(12);
    check("wrap_bit_count", 32'(tif.o_bit_count), 0);
    send_byte(8'hA5, 1'b1);
    tick(12);
    check("hold_rx_byte", 32'(tif.o_recieved_byte), 32'h0A5);

    // Load 0x3C on a ready pulse; the next byte's MISO must be 0x3C.
    load_val = 8'h3C;
    load_arm = 1'b1;
    send_byte(8'h00, 1'b0);
    check("load_taken", 32'(load_arm), 0);
    send_byte(8'h5A, 1'b0);
    check("miso_bits", 32'(miso_cap), 32'h03C);
    tick(12);

    // Shifting disabled: SCLK edges ignored.
    tif.i_shift_en = 1'b0;
    for (int i = 0; i < 3; i++) spi_bit(1'b1);
    tick(6);
    check("shift_en_off_count", 32'(tif.o_bit_count), 0);
    tif.i_shift_en = 1'b1;

    // Five bits then CS high: partial byte discarded, no pulse.
    spi_bit(1'b1); spi_bit(1'b0); spi_bit(1'b1); spi_bit(1'b1); spi_bit(1'b0);
    tick(12);
    check("partial_count", 32'(tif.o_bit_count), 5);
    tif.i_tx_byte = 8'hFF;
    tif.i_shift_reg_par_load = 1'b1;
    tick(1);
    tif.i_shift_reg_par_load = 1'b0;
    check("miso_active", 32'(miso), 1);
    cs = 1'b1;
    tick(8);
    check("abort_count", 32'(tif.o_bit_count), 0);
    check("abort_state", 32'(fsm_dbg), 0);
    check("miso_idle", 32'(miso), 0);
    cs = 1'b0;
    tick(6);
    send_byte(8'hFF, 1'b0);
    tick(12);

    // Count clear coinciding with a rise strobe drops that bit.
    spi_bit(1'b1); spi_bit(1'b1); spi_bit(1'b1);
    tick(6);
    check("pre_clr_count", 32'(tif.o_bit_count), 3);
    mosi = 1'b1;
    tick(HALF);
    sclk = 1'b1;
    tick(S);
    tif.i_count_clr = 1'b1;
    tick(1);
    tif.i_count_clr = 1'b0;
    tick(HALF - S - 1);
    sclk = 1'b0;
    tick(6);
    check("clr_count", 32'(tif.o_bit_count), 0);
    send_byte(8'h96, 1'b0);
    tick(12);

    // Reset after three bits, then a full 0x81.
    spi_bit(1'b1); spi_bit(1'b0); spi_bit(1'b1);
    rst_n = 1'b0;
    tick(1);
    check("midrst_count", 32'(tif.o_bit_count), 0);
    check("midrst_rx_byte", 32'(tif.o_recieved_byte), 0);
    check("midrst_state", 32'(fsm_dbg), 0);
    tick(2);
    rst_n = 1'b1;
    tick(6);
    send_byte(8'h81, 1'b0);
    tick(12);

    // Three back-to-back bytes without a CS gap.
    send_byte(8'h02, 1'b0);
    send_byte(8'h10, 1'b0);
    send_byte(8'h55, 1'b0);
    tick(12);
    cs = 1'b1;
    tick(6);

    check("pending_expected", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
